// File: rtl/subpel_hfilter_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : subpel_hfilter_stream                                            |
// | Desc    : HEVC luma horizontal quarter/half/three-quarter filter, 2-stage  |
// |           stallable valid/ready pipeline with block framing.               |
// |           Define SUBPEL_CLIP_EN to saturate results, else they wrap.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module subpel_hfilter_stream #(
  parameter int NUM_PIXEL = 8,
  parameter int BITDEPTH  = 8,
  parameter int BLK_ROWS  = 15,
  parameter int ROW_W     = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [(NUM_PIXEL+7)*BITDEPTH-1:0]  in_row_i,
  input  logic                               in_last_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_PIXEL*BITDEPTH-1:0]      out_a_o,
  output logic [NUM_PIXEL*BITDEPTH-1:0]      out_b_o,
  output logic [NUM_PIXEL*BITDEPTH-1:0]      out_c_o,
  output logic                               out_last_o,
  output logic [ROW_W-1:0]                   out_row_o,
  output logic                               busy_o,
  output logic                               err_len_o
);

  localparam int ACC_W = BITDEPTH + 8;
  localparam logic signed [ACC_W-1:0] C_RND      = ACC_W'(32);
  localparam logic [ROW_W-1:0]        C_LAST_IDX = ROW_W'(BLK_ROWS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             err_q, err_d;
  logic             v1_q, v2_q;
  logic             last1_q, last2_q;
  logic [ROW_W-1:0] row1_q, row2_q;
  logic             en, accept, out_xfer;

  function automatic logic signed [ACC_W-1:0] px(input logic [BITDEPTH-1:0] p);
    return $signed({8'd0, p});
  endfunction

  function automatic logic [BITDEPTH-1:0] round_out(input logic signed [ACC_W-1:0] lo,
                                                    input logic signed [ACC_W-1:0] hi);
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] r;
    s = lo + hi + C_RND;
    r = s >>> 6;
`ifdef SUBPEL_CLIP_EN
    if (r < 0)
      return '0;
    else if (r > $signed({8'd0, {BITDEPTH{1'b1}}}))
      return '1;
    else
      return r[BITDEPTH-1:0];
`else
    return r[BITDEPTH-1:0];
`endif
  endfunction

  // The whole pipeline moves as one; only a held stage-2 result blocks it.
  assign en         = !v2_q || out_ready_i;
  assign in_ready_o = en && (state_q != S_DRAIN);
  assign accept     = in_valid_i && in_ready_o;
  assign out_xfer   = v2_q && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last_i ? S_DRAIN : S_RUN;
      S_RUN:   if (accept && in_last_i) state_d = S_DRAIN;
      S_DRAIN: if (out_xfer && last2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_comb begin
    row_d = row_q;
    err_d = err_q;
    if (accept) begin
      if (in_last_i || (row_q == C_LAST_IDX)) row_d = '0;
      else                                    row_d = row_q + ROW_W'(1);
      if (in_last_i != (row_q == C_LAST_IDX)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q   <= '0;
      err_q   <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      row1_q  <= '0;
      row2_q  <= '0;
    end else begin
      row_q <= row_d;
      err_q <= err_d;
      if (en) begin
        v1_q    <= accept;
        v2_q    <= v1_q;
        last1_q <= in_last_i;
        last2_q <= last1_q;
        row1_q  <= row_q;
        row2_q  <= row1_q;
      end
    end
  end

  assign out_valid_o = v2_q;
  assign out_last_o  = last2_q;
  assign out_row_o   = row2_q;
  assign err_len_o   = err_q;

  for (genvar i = 0; i < NUM_PIXEL; i++) begin : g_lane
    logic signed [ACC_W-1:0] x [8];
    logic signed [ACC_W-1:0] a_lo_d, a_hi_d, b_lo_d, b_hi_d, c_lo_d, c_hi_d;
    logic signed [ACC_W-1:0] a_lo_q, a_hi_q, b_lo_q, b_hi_q, c_lo_q, c_hi_q;
    logic [BITDEPTH-1:0]     a_q, b_q, c_q;

    for (genvar k = 0; k < 8; k++) begin : g_tap
      assign x[k] = px(in_row_i[(i+k)*BITDEPTH +: BITDEPTH]);
    end

    // Tap weights built from shifts: 58=64-4-2, 40=32+8, 17=16+1, 11=8+2+1, 10=8+2, 5=4+1.
    assign a_lo_d = -x[0] + (x[1] <<< 2) - ((x[2] <<< 3) + (x[2] <<< 1))
                    + ((x[3] <<< 6) - (x[3] <<< 2) - (x[3] <<< 1));
    assign a_hi_d = ((x[4] <<< 4) + x[4]) - ((x[5] <<< 2) + x[5]) + x[6];
    assign b_lo_d = -x[0] + (x[1] <<< 2) - ((x[2] <<< 3) + (x[2] <<< 1) + x[2])
                    + ((x[3] <<< 5) + (x[3] <<< 3));
    assign b_hi_d = ((x[4] <<< 5) + (x[4] <<< 3)) - ((x[5] <<< 3) + (x[5] <<< 1) + x[5])
                    + (x[6] <<< 2) - x[7];
    assign c_lo_d = x[1] - ((x[2] <<< 2) + x[2]) + ((x[3] <<< 4) + x[3]);
    assign c_hi_d = ((x[4] <<< 6) - (x[4] <<< 2) - (x[4] <<< 1))
                    - ((x[5] <<< 3) + (x[5] <<< 1)) + (x[6] <<< 2) - x[7];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_lo_q <= '0;
        a_hi_q <= '0;
        b_lo_q <= '0;
        b_hi_q <= '0;
        c_lo_q <= '0;
        c_hi_q <= '0;
        a_q    <= '0;
        b_q    <= '0;
        c_q    <= '0;
      end else if (en) begin
        a_lo_q <= a_lo_d;
        a_hi_q <= a_hi_d;
        b_lo_q <= b_lo_d;
        b_hi_q <= b_hi_d;
        c_lo_q <= c_lo_d;
        c_hi_q <= c_hi_d;
        a_q    <= round_out(a_lo_q, a_hi_q);
        b_q    <= round_out(b_lo_q, b_hi_q);
        c_q    <= round_out(c_lo_q, c_hi_q);
      end
    end

    assign out_a_o[i*BITDEPTH +: BITDEPTH] = a_q;
    assign out_b_o[i*BITDEPTH +: BITDEPTH] = b_q;
    assign out_c_o[i*BITDEPTH +: BITDEPTH] = c_q;
  end

endmodule
`default_nettype wire
